// File: rtl/usart_pkg.sv
// Shared types and defaults for the usart receive FIFO (usart_fila).
package usart_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    RECEBENDO  = 2'd1,
    RESFRIANDO = 2'd2
  } estado_t;

  localparam int LARGURA_PADRAO      = 32;
  localparam int PROFUNDIDADE_PADRAO = 4;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int larg_ptr(input int prof);
    return (prof > 1) ? $clog2(prof) : 1;
  endfunction

endpackage

// File: rtl/usart_fila_mem.sv
// FIFO storage for usart_fila: synchronous write, registered read,
// natural-wrap pointers and an occupancy count that cannot over/underflow.
module usart_fila_mem
  import usart_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  localparam int PW          = larg_ptr(PROFUNDIDADE),
  localparam int CW          = PW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [LARGURA-1:0] dado_i,
  output logic [LARGURA-1:0] dado_o,
  output logic               valido_o,
  output logic [CW-1:0]      contagem_o,
  output logic               vazia_o,
  output logic               cheia_o
);

  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
  logic [PW-1:0]      ptr_wr_q, ptr_rd_q;
  logic [CW-1:0]      cont_q;
  logic [LARGURA-1:0] saida_q;
  logic               valido_q;
  logic               pop_ok, push_ok;

  assign vazia_o    = (cont_q == '0);
  assign cheia_o    = (cont_q == CW'(PROFUNDIDADE));
  assign contagem_o = cont_q;
  assign dado_o     = saida_q;
  assign valido_o   = valido_q;

  // A pop on an empty FIFO is dropped; a push into a full FIFO is only
  // accepted when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop_i & ~vazia_o;
  assign push_ok = push_i & (~cheia_o | pop_ok);

  // Storage array: write-only port, no reset needed on the data.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[ptr_wr_q] <= dado_i;
  end

  // Pointers, count and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_wr_q <= '0;
      ptr_rd_q <= '0;
      cont_q   <= '0;
      saida_q  <= '0;
      valido_q <= 1'b0;
    end else begin
      valido_q <= pop_ok;
      if (push_ok) ptr_wr_q <= ptr_wr_q + PW'(1);
      if (pop_ok) begin
        ptr_rd_q <= ptr_rd_q + PW'(1);
        saida_q  <= mem_q[ptr_rd_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   cont_q <= cont_q + CW'(1);
        2'b01:   cont_q <= cont_q - CW'(1);
        default: cont_q <= cont_q;
      endcase
    end
  end

endmodule

// File: rtl/usart_fila.sv
// usart_fila: drives the usart `controle` line, captures each received word
// into a small FIFO and serves pops from the processor.
// Optional receive watchdog: define USART_FILA_TIMEOUT_EN.
//
// state      | meaning
// OCIOSO     | receiver cleared (controle=0), waiting for enable and room
// RECEBENDO  | reception armed (controle=1), waiting for dado_pronto
// RESFRIANDO | one cycle with controle=0 so the usart clears its index/flags
module usart_fila
  import usart_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
`ifdef USART_FILA_TIMEOUT_EN
  parameter int TIMEOUT      = 4096,
`endif
  localparam int CW          = larg_ptr(PROFUNDIDADE) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               habilitar_rx,
  output logic               controle,
  input  logic [LARGURA-1:0] dado_rx,
  input  logic               dado_pronto,
  input  logic               req_leitura,
  output logic [LARGURA-1:0] dado_saida,
  output logic               dado_valido,
  output logic               fila_vazia,
  output logic               fila_cheia,
  output logic [CW-1:0]      contagem
`ifdef USART_FILA_TIMEOUT_EN
  ,
  output logic               erro_timeout
`endif
);

  estado_t estado_q, estado_d;
  logic    controle_q, controle_d;
  logic    push;
  logic    pop_ok;

`ifdef USART_FILA_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          erro_q, erro_d;
  logic          estouro;
`endif

  assign pop_ok   = req_leitura & ~fila_vazia;
  assign controle = controle_q;

  // Next state, push strobe and watchdog bookkeeping.
  always_comb begin
    estado_d = estado_q;
    push     = 1'b0;
`ifdef USART_FILA_TIMEOUT_EN
    tmr_d    = tmr_q;
    estouro  = 1'b0;
`endif
    case (estado_q)
      OCIOSO: begin
        if (habilitar_rx && !fila_cheia) begin
          estado_d = RECEBENDO;
`ifdef USART_FILA_TIMEOUT_EN
          tmr_d    = TW'(TIMEOUT - 1);
`endif
        end
      end
      RECEBENDO: begin
        if (dado_pronto) begin
          // With no room the word stays in the usart until space appears.
          if (!fila_cheia || pop_ok) begin
            push     = 1'b1;
            estado_d = RESFRIANDO;
          end
        end else if (!habilitar_rx) begin
          estado_d = OCIOSO;
        end
`ifdef USART_FILA_TIMEOUT_EN
        else if (tmr_q == '0) begin
          estouro  = 1'b1;
          estado_d = RESFRIANDO;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
`endif
      end
      RESFRIANDO: estado_d = OCIOSO;
      default:    estado_d = OCIOSO;
    endcase
    controle_d = (estado_d == RECEBENDO);
`ifdef USART_FILA_TIMEOUT_EN
    erro_d = erro_q;
    if (estouro)                         erro_d = 1'b1;
    else if (req_leitura && !habilitar_rx) erro_d = 1'b0;
`endif
  end

  // State and registered controle output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      controle_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      controle_q <= controle_d;
    end
  end

`ifdef USART_FILA_TIMEOUT_EN
  // Watchdog down-counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      erro_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      erro_q <= erro_d;
    end
  end

  assign erro_timeout = erro_q;
`endif

  usart_fila_mem #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (req_leitura),
    .dado_i     (dado_rx),
    .dado_o     (dado_saida),
    .valido_o   (dado_valido),
    .contagem_o (contagem),
    .vazia_o    (fila_vazia),
    .cheia_o    (fila_cheia)
  );

endmodule

// File: tb/tb_usart_fila.sv
// Bench for usart_fila: usart stand-in plus a queue-based reference model.
module tb_usart_fila;

  localparam int L  = 32;
  localparam int D  = 4;
  localparam int CW = 3;
`ifdef USART_FILA_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          habilitar_rx = 1'b0;
  logic          controle;
  logic [L-1:0]  dado_rx = '0;
  logic          dado_pronto = 1'b0;
  logic          req_leitura = 1'b0;
  logic [L-1:0]  dado_saida;
  logic          dado_valido;
  logic          fila_vazia;
  logic          fila_cheia;
  logic [CW-1:0] contagem;
`ifdef USART_FILA_TIMEOUT_EN
  logic          erro_timeout;
`endif

  always #5 clk = ~clk;

  usart_fila #(
    .LARGURA      (L),
    .PROFUNDIDADE (D)
`ifdef USART_FILA_TIMEOUT_EN
    , .TIMEOUT    (TMO)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .habilitar_rx (habilitar_rx),
    .controle     (controle),
    .dado_rx      (dado_rx),
    .dado_pronto  (dado_pronto),
    .req_leitura  (req_leitura),
    .dado_saida   (dado_saida),
    .dado_valido  (dado_valido),
    .fila_vazia   (fila_vazia),
    .fila_cheia   (fila_cheia),
    .contagem     (contagem)
`ifdef USART_FILA_TIMEOUT_EN
    , .erro_timeout (erro_timeout)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // usart stand-in: words waiting to be "received" and a random gap.
  logic [31:0] tx_q[$];
  int          gap = 0;
  int          gap_max = 0;

  // Reference model: FIFO contents plus the receive handshake phase.
  logic [31:0] mq[$];
  logic        armed_m = 1'b0;
  logic        cool_m = 1'b0;
  logic [31:0] exp_saida = '0;
  logic        exp_val = 1'b0;
  logic        erro_m = 1'b0;
  int          wait_m = 0;

  task automatic modelo_reset();
    mq.delete();
    armed_m = 1'b0; cool_m = 1'b0;
    exp_saida = '0; exp_val = 1'b0;
    erro_m = 1'b0; wait_m = 0;
  endtask

  task automatic modelo_borda();
    int  n0;
    bit  pop;
    n0  = mq.size();
    pop = req_leitura && (n0 > 0);
    if (pop) begin
      exp_saida = mq.pop_front();
      exp_val   = 1'b1;
    end else begin
      exp_val = 1'b0;
    end
    if (req_leitura && !habilitar_rx) erro_m = 1'b0;
    if (armed_m) begin
      if (dado_pronto) begin
        if (n0 < D || pop) begin
          mq.push_back(dado_rx);
          armed_m = 1'b0; cool_m = 1'b1;
        end
      end else if (!habilitar_rx) begin
        armed_m = 1'b0;
      end else begin
        wait_m++;
`ifdef USART_FILA_TIMEOUT_EN
        if (wait_m == TMO) begin
          erro_m = 1'b1; armed_m = 1'b0; cool_m = 1'b1;
        end
`endif
      end
    end else if (cool_m) begin
      cool_m = 1'b0;
    end else if (habilitar_rx && n0 < D) begin
      armed_m = 1'b1; wait_m = 0;
    end
  endtask

  task automatic conferir();
    verificar("controle", controle, armed_m);
    verificar("contagem", contagem, 32'(mq.size()));
    verificar("fila_vazia", fila_vazia, mq.size() == 0);
    verificar("fila_cheia", fila_cheia, mq.size() == D);
    verificar("dado_valido", dado_valido, exp_val);
    verificar("dado_saida", dado_saida, exp_saida);
`ifdef USART_FILA_TIMEOUT_EN
    verificar("erro_timeout", erro_timeout, erro_m);
`endif
  endtask

  // One clock: drive on negedge, model on posedge, compare 1 ns later.
  task automatic passo(input logic h, input logic r);
    @(negedge clk);
    habilitar_rx = h;
    req_leitura  = r;
    if (!controle) begin
      dado_pronto = 1'b0;
    end else if (!dado_pronto && tx_q.size() > 0) begin
      if (gap == 0) begin
        dado_rx     = tx_q.pop_front();
        dado_pronto = 1'b1;
        gap         = $urandom_range(0, gap_max);
      end else begin
        gap--;
      end
    end
    @(posedge clk);
    modelo_borda();
    #1 conferir();
  endtask

  task automatic passos(input int n, input logic h);
    for (int i = 0; i < n; i++) passo(h, 1'b0);
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    verificar("rst_controle", controle, 1'b0);
    verificar("rst_contagem", contagem, 0);
    verificar("rst_vazia", fila_vazia, 1'b1);
    verificar("rst_cheia", fila_cheia, 1'b0);
    verificar("rst_saida", dado_saida, 0);
    verificar("rst_valido", dado_valido, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    modelo_reset();
    passos(6, 1'b0);

    // Single word
    tx_q.push_back(32'hDEADBEEF);
    passos(10, 1'b1);
    verificar("single_contagem", contagem, 1);
    passo(1'b0, 1'b1);
    verificar("single_dado", dado_saida, 32'hDEADBEEF);
    verificar("single_valido", dado_valido, 1'b1);
    passo(1'b0, 1'b0);
    verificar("single_valido_pulse", dado_valido, 1'b0);

    // Fill and backpressure
    for (int i = 1; i <= 5; i++) tx_q.push_back(32'(i));
    passos(30, 1'b1);
    verificar("fill_contagem", contagem, 4);
    verificar("fill_cheia", fila_cheia, 1'b1);
    passo(1'b1, 1'b1);
    verificar("fill_pop1", dado_saida, 1);
    passos(10, 1'b1);
    verificar("fill_refill", contagem, 4);
    for (int i = 2; i <= 5; i++) begin
      passo(1'b0, 1'b1);
      verificar("fill_pop", dado_saida, 32'(i));
    end

    // Empty read
    passo(1'b0, 1'b1);
    verificar("empty_valido", dado_valido, 1'b0);
    verificar("empty_saida", dado_saida, 5);
    passo(1'b0, 1'b1);

    // Async reset mid-reception with two words stored
    tx_q.push_back(32'hA1);
    tx_q.push_back(32'hA2);
    passos(14, 1'b1);
    verificar("mid_contagem", contagem, 2);
    verificar("mid_controle", controle, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    verificar("mid_rst_controle", controle, 1'b0);
    verificar("mid_rst_contagem", contagem, 0);
    verificar("mid_rst_vazia", fila_vazia, 1'b1);
    @(negedge clk);
    habilitar_rx = 1'b0; req_leitura = 1'b0; dado_pronto = 1'b0;
    tx_q.delete(); gap = 0;
    modelo_reset();
    rst_n = 1'b1;
    tx_q.push_back(32'hB0);
    passos(10, 1'b1);
    passo(1'b0, 1'b1);
    verificar("mid_first_after", dado_saida, 32'hB0);
    passos(2, 1'b0);

`ifdef USART_FILA_TIMEOUT_EN
    // Watchdog: arm with no word coming
    passos(TMO + 2, 1'b1);
    verificar("tmo_erro", erro_timeout, 1'b1);
    verificar("tmo_contagem", contagem, 0);
    passo(1'b0, 1'b1);
    verificar("tmo_clear", erro_timeout, 1'b0);
    passos(2, 1'b0);
`endif

    // Random traffic, light then heavy reads
    gap_max = 3;
    for (int i = 0; i < 800; i++) begin
      if (tx_q.size() < 2) tx_q.push_back($urandom);
      passo($urandom_range(0, 9) != 0,
            (i < 400) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 4));
    end
    passos(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usart_fila.md
Name: usart_fila

Overview:
- Downstream consumer of the serial receiver (usart).
- Owns the receiver's `controle` line: arms a reception, waits for `dado_pronto`, captures the 32-bit `dado` word and pushes it into a small FIFO.
- Re-arms the receiver for the next word.
- The processor's input instruction pops words from the FIFO through a one-cycle request/valid handshake.

Parameters:
- LARGURA, 32, width of the received word and of each FIFO entry.
- PROFUNDIDADE, 4, number of FIFO entries; power of two, at least 2.
- TIMEOUT, 4096, cycles to wait for `dado_pronto` before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- habilitar_rx  in  1  level; 1 = keep receiving words.
- controle  out  1  to usart `controle`; 1 = reception armed, 0 = clears usart.
- dado_rx  in  LARGURA  from usart `dado`.
- dado_pronto  in  1  from usart `dado_pronto`.
- req_leitura  in  1  processor pop request, one-cycle pulse.
- dado_saida  out  LARGURA  popped word.
- dado_valido  out  1  one-cycle pulse; `dado_saida` is valid.
- fila_vazia  out  1  FIFO empty.
- fila_cheia  out  1  FIFO full.
- contagem  out  $clog2(PROFUNDIDADE)+1  entries held.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state OCIOSO, controle=0, pointers=0, contagem=0.
  - fila_vazia=1, fila_cheia=0.
  - dado_saida=0, dado_valido=0.
- Reset mid-reception drops the partial word. controle falls immediately, so usart clears.
- The usart updates on negedge. This block samples `dado_pronto`/`dado_rx` on posedge, half a cycle later, so no synchronizer is needed.
- FSM, registered outputs:
  - OCIOSO: controle=0.
    - habilitar_rx=1 and fila_cheia=0 -> RECEBENDO.
    - Otherwise stay.
  - RECEBENDO: controle=1.
    - dado_pronto=1 and (fila_cheia=0 or a pop in the same cycle): push dado_rx, go to RESFRIANDO.
    - dado_pronto=1 and full with no pop: stay. controle stays high, so usart holds the word and no data is lost.
    - habilitar_rx falling while dado_pronto=0 -> OCIOSO; the partial word is discarded.
  - RESFRIANDO: controle=0 for exactly one cycle (clears usart index/flags) -> OCIOSO.
- Minimum spacing between pushes is 3 cycles plus the usart reception time.
- Read:
  - req_leitura=1 with fila_vazia=0 pops the head. Next cycle dado_saida=head and dado_valido=1 for one cycle.
  - req_leitura with fila_vazia=1 is ignored: dado_valido=0, dado_saida holds its previous value.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full; contagem is unchanged.
  - When empty, the pop is ignored and the push proceeds.
- Pointers are $clog2(PROFUNDIDADE) bits and wrap naturally.
- contagem saturates by construction: it never exceeds PROFUNDIDADE and never drops below 0.
- fila_cheia = (contagem==PROFUNDIDADE); fila_vazia = (contagem==0). Both are derived combinationally from the registered count.

Optional Feature:
- Macro USART_FILA_TIMEOUT_EN.
- Enabled:
  - Adds output erro_timeout (1 bit, sticky) and a cycle counter that clears on entry to RECEBENDO.
  - If RECEBENDO lasts TIMEOUT cycles without dado_pronto: erro_timeout=1, go to RESFRIANDO, nothing is pushed.
  - erro_timeout is cleared only by reset or by a req_leitura pulse while habilitar_rx=0.
- Disabled: no port, no counter; RECEBENDO waits indefinitely.

Decomposition:
- Shared package usart_pkg:
  - state enum {OCIOSO, RECEBENDO, RESFRIANDO}.
  - default LARGURA=32.
  - localparam for the pointer width function.
- One sub-module, usart_fila_mem: a synchronous-write, registered-read FIFO storage with pointers and count.
- The FSM and timeout stay in the top module.

Test Plan:
- Reset and idle: rst_n low, then high with habilitar_rx=0 → controle=0, fila_vazia=1, contagem=0, dado_valido never pulses.
- Single word: habilitar_rx=1; usart model returns 32'hDEADBEEF with dado_pronto → controle shows a one-cycle low pulse, contagem=1. req_leitura → next cycle dado_saida=32'hDEADBEEF, dado_valido=1 for one cycle.
- Fill and backpressure: 5 words 1..5 with no reads:
  - contagem=4, fifth word held with controle=1.
  - One pop returns 1, and the same cycle pushes 5.
  - Subsequent pops return 2,3,4,5.
- Empty read: req_leitura with fila_vazia=1 → dado_valido=0, contagem stays 0, pointers unchanged.
- Async reset mid-reception: rst_n low while in RECEBENDO with 2 words stored → controle=0 immediately, contagem=0, and the next word after re-enable is read back first.
- Timeout (USART_FILA_TIMEOUT_EN, TIMEOUT=16): no dado_pronto → erro_timeout=1 at cycle 16, controle pulses low, nothing pushed, re-arm follows.
